// File: rtl/pe_pkg.sv
// Shared types and helpers for the ternary weight-stationary processing element.
//   pe_state_t  : weight-buffer lifecycle (EMPTY -> LOAD -> RUN)
//   tern_w_t    : 2-bit ternary weight code
//   tern_decode : code -> signed {-1, 0, +1}
package pe_pkg;

  typedef enum logic [1:0] {
    PE_EMPTY = 2'b00,
    PE_LOAD  = 2'b01,
    PE_RUN   = 2'b10
  } pe_state_t;

  typedef logic [1:0] tern_w_t;

  localparam tern_w_t TERN_POS  = 2'b01;
  localparam tern_w_t TERN_NEG  = 2'b11;
  localparam tern_w_t TERN_ZERO = 2'b00;

  // Reserved code 2'b10 decodes to zero.
  function automatic logic signed [1:0] tern_decode(input tern_w_t code);
    case (code)
      TERN_POS:  return 2'sb01;
      TERN_NEG:  return 2'sb11;
      TERN_ZERO: return 2'sb00;
      default:   return 2'sb00;
    endcase
  endfunction

endpackage

// File: rtl/pe_weight_buffer.sv
// Circular DEPTH x 2-bit ternary weight register file.
//   clock, reset_n : clock / async active-low reset
//   enable         : clock enable, low holds everything
//   clear          : synchronous pointer reset (wins over write/advance)
//   wr_en, wr_data : write wr_data at wr_ptr, then wr_ptr++
//   rd_adv         : rd_ptr++ (wraps DEPTH-1 -> 0)
//   rd_data        : entry at rd_ptr (before any same-cycle advance)
//   last_wr_c      : the next write fills the final entry
module pe_weight_buffer
  import pe_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic    clock,
  input  logic    reset_n,
  input  logic    enable,
  input  logic    clear,
  input  logic    wr_en,
  input  tern_w_t wr_data,
  input  logic    rd_adv,
  output tern_w_t rd_data,
  output logic    last_wr_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  tern_w_t            mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (enable) begin
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en) begin
          mem[wr_ptr] <= wr_data;
          wr_ptr      <= wr_ptr + PTR_W'(1);
        end
        if (rd_adv) rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  assign rd_data   = mem[rd_ptr];
  assign last_wr_c = (wr_ptr == PTR_W'(DEPTH - 1));

endmodule

// File: rtl/ternary_pe_wbuf.sv
// Weight-stationary ternary processing element with a local circular weight buffer.
// Each valid beat: psum_out = psum_in + w*data_in (add / subtract / bypass), data forwarded east.
//   clock, reset_n        : clock / async active-low reset
//   enable                : clock enable; low freezes all state, load ready forced low
//   wgt_clear             : flush weight buffer back to EMPTY, clears sat_flag
//   wgt_load_valid/data   : weight load beat; wgt_load_ready high while buffer not full
//   wgt_read              : advance weight read pointer (RUN only)
//   in_valid, data_in, psum_in   : input beat from west / north
//   out_valid, data_out, psum_out: registered beat to east / south
//   sat_flag              : sticky saturation / overflow indicator
//   run                   : buffer full, weights in use
module ternary_pe_wbuf
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned PSUM_W   = 24,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned SATURATE = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              wgt_clear,
  input  logic              wgt_load_valid,
  input  logic [1:0]        wgt_load_data,
  output logic              wgt_load_ready,
  input  logic              wgt_read,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic [PSUM_W-1:0] psum_in,
  output logic              out_valid,
  output logic [DATA_W-1:0] data_out,
  output logic [PSUM_W-1:0] psum_out,
  output logic              sat_flag,
  output logic              run
);

  localparam int unsigned SUM_W = PSUM_W + 1;

  pe_state_t   state_q, state_d;
  logic        ready_q;
  logic        wr_en_c, rd_adv_c, last_wr_c;
  tern_w_t     rd_data;

  pe_weight_buffer #(.DEPTH(DEPTH)) u_wbuf (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .clear     (wgt_clear),
    .wr_en     (wr_en_c),
    .wr_data   (wgt_load_data),
    .rd_adv    (rd_adv_c),
    .rd_data   (rd_data),
    .last_wr_c (last_wr_c)
  );

  // State and load-ready registers; ready_q stays low through reset until the first enabled edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PE_EMPTY;
      ready_q <= 1'b0;
    end else if (enable) begin
      state_q <= state_d;
      ready_q <= (state_d != PE_RUN);
    end
  end

  // Next-state and buffer control; clear overrides any same-cycle load or read.
  always_comb begin
    state_d  = state_q;
    wr_en_c  = 1'b0;
    rd_adv_c = 1'b0;
    case (state_q)
      PE_EMPTY: begin
        if (ready_q && wgt_load_valid) begin
          wr_en_c = 1'b1;
          state_d = PE_LOAD;
        end
      end
      PE_LOAD: begin
        if (ready_q && wgt_load_valid) begin
          wr_en_c = 1'b1;
          if (last_wr_c) state_d = PE_RUN;
        end
      end
      PE_RUN:  rd_adv_c = wgt_read;
      default: state_d  = PE_EMPTY;
    endcase
    if (wgt_clear) begin
      state_d  = PE_EMPTY;
      wr_en_c  = 1'b0;
      rd_adv_c = 1'b0;
    end
  end

  assign wgt_load_ready = enable && ready_q;
  assign run            = (state_q == PE_RUN);

  // Ternary add/sub/bypass at PSUM_W+1 bits, so -(-2^(DATA_W-1)) is exact.
  logic signed [1:0]       w_c;
  logic signed [SUM_W-1:0] data_ext_c, psum_ext_c, sum_c;
  logic                    ovf_c;
  logic [PSUM_W-1:0]       result_c;

  always_comb begin
    w_c        = (state_q == PE_RUN) ? tern_decode(rd_data) : 2'sb00;
    data_ext_c = SUM_W'($signed(data_in));
    psum_ext_c = SUM_W'($signed(psum_in));
    case (w_c)
      2'sb01:  sum_c = psum_ext_c + data_ext_c;
      2'sb11:  sum_c = psum_ext_c - data_ext_c;
      default: sum_c = psum_ext_c;
    endcase
    ovf_c    = sum_c[SUM_W-1] ^ sum_c[SUM_W-2];
    result_c = sum_c[PSUM_W-1:0];
    if ((SATURATE != 0) && ovf_c)
      result_c = sum_c[SUM_W-1] ? {1'b1, {(PSUM_W-1){1'b0}}} : {1'b0, {(PSUM_W-1){1'b1}}};
  end

  // Output pipeline; data/psum hold when no beat arrives.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      psum_out  <= '0;
      sat_flag  <= 1'b0;
    end else if (enable) begin
      out_valid <= in_valid;
      if (in_valid) begin
        data_out <= data_in;
        psum_out <= result_c;
        if (ovf_c) sat_flag <= 1'b1;
      end
      if (wgt_clear) sat_flag <= 1'b0;
    end
  end

endmodule
